// File: rtl/dma_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : dma_bus_pkg
// Brief   : Shared types and default timeouts for the system bus arbiter and
//           the DMA controllers that request the bus.
// Rev     : 1.0 - initial release
// ============================================================================
package dma_bus_pkg;

  localparam int MASTER_ID_W      = 3;
  localparam int DEF_GRANT_WAIT   = 16;
  localparam int DEF_BUSY_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT      = 3'd1,
    ST_WAIT_BEGIN = 3'd2,
    ST_BUSY       = 3'd3,
    ST_RELEASE    = 3'd4
  } arb_state_e;

endpackage : dma_bus_pkg
`default_nettype wire

// File: rtl/dma_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector; first request at or after
//          (ptr+1) mod N, found by scanning a doubled request vector.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_pick
  import dma_bus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]           request,
  input  logic [MASTER_ID_W-1:0] ptr,
  output logic [MASTER_ID_W-1:0] pick,
  output logic                   any_req
);

  logic [2*N-1:0] w_dbl;

  // Scan offsets from far to near so the nearest requester overwrites last.
  always_comb begin
    w_dbl   = {request, request};
    pick    = '0;
    any_req = |request;
    for (int i = N; i >= 1; i--) begin
      if (w_dbl[int'(ptr) + i]) begin
        pick = MASTER_ID_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dma_bus_arbiter
// Brief  : Round-robin owner of the shared system bus with grant-wait and
//          busy watchdogs that reclaim the bus from stalled masters.
// Rev    : 1.0 - initial release
// ============================================================================
module dma_bus_arbiter
  import dma_bus_pkg::*;
#(
  parameter int NUM_MASTERS  = 4,
  parameter int GRANT_WAIT   = DEF_GRANT_WAIT,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic [NUM_MASTERS-1:0] request,
  input  logic                   begin_transaction,
  input  logic                   end_transaction,
  input  logic                   bus_error_in,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [MASTER_ID_W-1:0] active_master,
  output logic                   bus_busy,
  output logic                   timeout_error
);

  localparam int c_WD_W = $clog2(BUSY_TIMEOUT) + 1;

  arb_state_e              r_state, w_state_nxt;
  logic [MASTER_ID_W-1:0]  r_active, w_active_nxt;
  logic [MASTER_ID_W-1:0]  r_ptr, w_ptr_nxt;
  logic [c_WD_W-1:0]       r_wd, w_wd_nxt, w_wd_inc;
  logic [MASTER_ID_W-1:0]  w_pick;
  logic                    w_any_req;
  logic                    w_timeout;

  rr_pick #(.N(NUM_MASTERS)) u_rr_pick (
    .request (request),
    .ptr     (r_ptr),
    .pick    (w_pick),
    .any_req (w_any_req)
  );

  // Watchdog saturates rather than wrapping back to zero.
  assign w_wd_inc = (r_wd == {c_WD_W{1'b1}}) ? r_wd : r_wd + 1'b1;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= ST_IDLE;
      r_active <= '0;
      r_ptr    <= MASTER_ID_W'(NUM_MASTERS - 1);
      r_wd     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
      r_ptr    <= w_ptr_nxt;
      r_wd     <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_ptr_nxt    = r_ptr;
    w_wd_nxt     = r_wd;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = ST_GRANT;
          w_active_nxt = w_pick;
          w_ptr_nxt    = w_pick;
        end
      end
      ST_GRANT: begin
        w_wd_nxt    = '0;
        w_state_nxt = ST_WAIT_BEGIN;
      end
      ST_WAIT_BEGIN: begin
        if (begin_transaction) begin
          w_state_nxt = ST_BUSY;
          w_wd_nxt    = '0;
        end else if (r_wd == c_WD_W'(GRANT_WAIT - 1)) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_wd_nxt = w_wd_inc;
        end
      end
      ST_BUSY: begin
        // A normal termination in the timeout cycle suppresses the abort pulse.
        if (end_transaction || bus_error_in) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_wd == c_WD_W'(BUSY_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_wd_nxt = w_wd_inc;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
    assign grant[gi] = (r_state == ST_GRANT) && (r_active == MASTER_ID_W'(gi));
  end

  assign active_master = r_active;
  assign bus_busy      = (r_state != ST_IDLE);
  assign timeout_error = w_timeout;

endmodule : dma_bus_arbiter
`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dma_bus_arbiter
// Brief  : Directed self-checking bench for the round-robin bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dma_bus_arbiter;

  logic       clock;
  logic       n_reset;
  logic [3:0] request;
  logic       begin_transaction;
  logic       end_transaction;
  logic       bus_error_in;
  logic [3:0] grant;
  logic [2:0] active_master;
  logic       bus_busy;
  logic       timeout_error;

  int n_pass  = 0;
  int n_total = 0;

  dma_bus_arbiter #(
    .NUM_MASTERS  (4),
    .GRANT_WAIT   (16),
    .BUSY_TIMEOUT (1024)
  ) dut (
    .clock             (clock),
    .n_reset           (n_reset),
    .request           (request),
    .begin_transaction (begin_transaction),
    .end_transaction   (end_transaction),
    .bus_error_in      (bus_error_in),
    .grant             (grant),
    .active_master     (active_master),
    .bus_busy          (bus_busy),
    .timeout_error     (timeout_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Waits (bounded) for the next grant; checks who got it and after how many cycles.
  task automatic wait_grant(input string tag, input int exp_m, input int exp_cyc);
    int cnt = 0;
    while (grant == 4'b0000 && cnt < 64) begin
      @(negedge clock);
      cnt++;
    end
    chk({tag, "_who"}, 32'(grant), 32'(1 << exp_m));
    chk({tag, "_lat"}, 32'(cnt), 32'(exp_cyc));
  endtask

  // From a grant cycle: begin, hold BUSY three cycles, end.
  task automatic do_txn(input string tag);
    @(negedge clock);
    begin_transaction = 1'b1;
    @(negedge clock);
    begin_transaction = 1'b0;
    chk({tag, "_busy"}, 32'(bus_busy), 32'd1);
    @(negedge clock);
    @(negedge clock);
    end_transaction = 1'b1;
    @(negedge clock);
    end_transaction = 1'b0;
    chk({tag, "_rel_grant"}, 32'(grant), 32'd0);
    chk({tag, "_rel_busy"}, 32'(bus_busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int pulses;
    int pulse_k;
    int bad;

    n_reset = 1'b0;
    request = 4'b1111;
    begin_transaction = 1'b0;
    end_transaction   = 1'b0;
    bus_error_in      = 1'b0;

    // Reset held with all masters requesting
    repeat (3) @(negedge clock);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(bus_busy), 32'd0);
    chk("rst_tmo", 32'(timeout_error), 32'd0);
    chk("rst_active", 32'(active_master), 32'd0);
    n_reset = 1'b1;
    wait_grant("first", 0, 1);

    // Fairness rotation 0,1,2,3,0
    do_txn("t0");
    wait_grant("rr1", 1, 2);
    chk("rr1_active", 32'(active_master), 32'd1);
    do_txn("t1");
    wait_grant("rr2", 2, 2);
    do_txn("t2");
    wait_grant("rr3", 3, 2);
    do_txn("t3");
    wait_grant("rr0", 0, 2);

    // Grant to master 2 that never begins
    request = 4'b0100;
    do_txn("t4");
    wait_grant("nb", 2, 2);
    request = 4'b0000;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      if (bus_busy !== 1'b1 || timeout_error !== 1'b0 || grant !== 4'b0000) bad++;
      end_transaction = (i == 3);
      bus_error_in    = (i == 3);
    end
    @(negedge clock);
    chk("nb_rel_busy", 32'(bus_busy), 32'd1);
    chk("nb_rel_tmo", 32'(timeout_error), 32'd0);
    @(negedge clock);
    chk("nb_idle_busy", 32'(bus_busy), 32'd0);
    chk("nb_wait_ok", 32'(bad), 32'd0);

    // Hung owner: master 1 begins, never ends; master 3 waits
    request = 4'b0010;
    wait_grant("hang", 1, 1);
    @(negedge clock);
    begin_transaction = 1'b1;
    @(negedge clock);
    begin_transaction = 1'b0;
    request = 4'b1000;
    pulses = 0;
    pulse_k = 0;
    for (int k = 1; k <= 1024; k++) begin
      if (k > 1) @(negedge clock);
      if (timeout_error === 1'b1) begin
        pulses++;
        pulse_k = k;
      end
    end
    chk("hang_pulses", 32'(pulses), 32'd1);
    chk("hang_cycle", 32'(pulse_k), 32'd1024);
    @(negedge clock);
    chk("hang_after_tmo", 32'(timeout_error), 32'd0);
    wait_grant("hang_next", 3, 2);

    // Simultaneous end and error in BUSY
    request = 4'b1010;
    @(negedge clock);
    begin_transaction = 1'b1;
    @(negedge clock);
    begin_transaction = 1'b0;
    end_transaction   = 1'b1;
    bus_error_in      = 1'b1;
    @(negedge clock);
    end_transaction = 1'b0;
    bus_error_in    = 1'b0;
    chk("dual_rel_busy", 32'(bus_busy), 32'd1);
    chk("dual_rel_tmo", 32'(timeout_error), 32'd0);
    @(negedge clock);
    chk("dual_idle_busy", 32'(bus_busy), 32'd0);
    chk("dual_idle_grant", 32'(grant), 32'd0);
    @(negedge clock);
    chk("dual_next", 32'(grant), 32'b0010);

    // Async reset mid-BUSY
    @(negedge clock);
    begin_transaction = 1'b1;
    @(negedge clock);
    begin_transaction = 1'b0;
    chk("ar_busy_before", 32'(bus_busy), 32'd1);
    chk("ar_active_before", 32'(active_master), 32'd1);
    #2;
    n_reset = 1'b0;
    request = 4'b1011;
    #1;
    chk("ar_busy_async", 32'(bus_busy), 32'd0);
    chk("ar_active_async", 32'(active_master), 32'd0);
    #1;
    n_reset = 1'b1;
    wait_grant("ar_next", 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dma_bus_arbiter
`default_nettype wire
